victim_select_param: RTL
========================

Name: victim_select_param

Overview:
- Parametrised successor to the 4-way "any but last used" eviction policy. It selects a victim way for an N-way, S-set cache controller.
- Adds per-set state: a last-used way tracker and a round-robin pointer. Adds a runtime mode select and a registered request/response with 1-cycle latency.
- Sits between the cache tag array (supplies valid and lock bits) and the fill/refill FSM (consumes the victim way).

Parameters:
- WAYS, 4, number of ways; power of 2, >= 2; WAY_W = $clog2(WAYS)
- SETS, 8, number of sets; power of 2, >= 1; SET_W = max(1, $clog2(SETS))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = any-but-last-used (ABLU), 1 = round-robin (RR); sampled with req_valid
- access_valid  in  1  hit/fill event; updates last-used state
- access_set  in  SET_W  set of the access
- access_way  in  WAY_W  way of the access
- req_valid  in  1  victim request; one per cycle, always accepted
- req_set  in  SET_W  set being refilled
- way_valid  in  WAYS  bit i = line i holds valid data
- way_locked  in  WAYS  bit i = way i must not be evicted
- victim_valid  out  1  response strobe, 1 cycle
- victim_way  out  WAY_W  selected way
- victim_none  out  1  no evictable way exists; victim_way = 0 when set

Behaviour:
- Reset (clk edge with rst=1):
  - victim_valid = victim_none = 0, victim_way = 0.
  - For all sets: lu_valid = 0, lu_way = 0, rr_ptr = 0.
  - A request in the reset cycle produces no response. rst dominates req_valid and access_valid.
- Latency: a request sampled at edge t drives victim_valid = 1 during cycle t+1 only. Outputs are registered. Back-to-back requests give back-to-back responses.
- Selection uses per-set state as held before edge t. An access in the same cycle, even to the same set, does not affect that request's result.
- Candidate masks:
  - inv = ~way_valid & ~way_locked
  - elig = way_valid & ~way_locked
- Priority 1, both modes: if inv != 0, pick the lowest-index set bit of inv.
- Priority 2, ABLU (mode = 0):
  - excl = elig with bit lu_way cleared if lu_valid, else excl = elig.
  - If excl != 0, pick its lowest-index set bit.
  - Else if elig != 0, pick lu_way (the only eligible way is the last-used one).
- Priority 2, RR (mode = 1):
  - Pick the first set bit of elig scanning upward from rr_ptr[req_set], wrapping WAYS-1 -> 0.
  - Last-used state is ignored in this mode.
- If no way is picked by either priority: victim_none = 1, victim_way = 0.
- rr_ptr update: only when mode = 1 and victim_none = 0, set rr_ptr[req_set] = (picked + 1) mod WAYS at edge t. This applies whether the pick came from priority 1 or 2. Wrap from WAYS-1 to 0.
- Last-used update: on access_valid at edge t, set lu_way[access_set] = access_way and lu_valid[access_set] = 1.
- Request without access, or access without request: only the relevant state changes.
- victim_valid = 0 implies victim_none = 0. victim_way holds its last value; the bench must not check it.
- State storage: flop arrays, SETS x (WAY_W+1) for last-used and SETS x WAY_W for rr_ptr. No RAM macros.
- Priority-encoder and rotate logic must be generic in WAYS; no hard-coded 4-way equations.

Test Plan (WAYS = 4, SETS = 8; masks written as bit3..bit0):
1. Reset, then req set 3, mode 0, valid 1111, locked 0000 -> next cycle victim_valid = 1, way 0, none 0. Request issued while rst = 1 -> no response.
2. Access set 3 way 0, then req set 3, mode 0, valid 1111, locked 0000 -> way 1. Same request with locked 0010 -> way 2.
3. Set 3 (lu = 0): valid 1011, locked 0000 -> way 2 (invalid priority). Valid 1011, locked 0100 -> way 1. Valid 1111, locked 1110 -> way 0 (only last-used eligible). Locked 1111 -> none = 1, way 0.
4. RR, set 5 from reset: five back-to-back reqs, valid 1111, locked 0000 -> ways 0, 1, 2, 3, 0 on consecutive cycles (wrap). Next req with locked 0010 (ptr = 1) -> way 2; following req with locked 0000 -> way 3.
5. Same-cycle access and request: access set 2 way 0, then in one cycle access set 2 way 1 plus req set 2, mode 0, valid 1111, locked 0000 -> way 1. Next identical req -> way 0.
6. Reset mid-operation: after scenario 5, assert rst for 1 cycle together with a req -> no response. Then req set 2, mode 0, valid 1111, locked 0000 -> way 0. RR req on set 5 -> way 0 (pointer cleared).

Source files
------------

// File: rtl/victim_select_param.sv
// Victim-way selector for an N-way, S-set cache: invalid-first, then either
// any-but-last-used or per-set round-robin, with a registered 1-cycle response.
module victim_select_set #(
    parameter int WAY_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_lu_we,
    input  logic [WAY_W-1:0] i_lu_way,
    input  logic             i_rr_we,
    input  logic [WAY_W-1:0] i_rr_nxt,
    output logic             o_lu_valid,
    output logic [WAY_W-1:0] o_lu_way,
    output logic [WAY_W-1:0] o_rr_ptr
);
    logic             r_lu_valid;
    logic [WAY_W-1:0] r_lu_way;
    logic [WAY_W-1:0] r_rr_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lu_valid <= 1'b0;
            r_lu_way   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (i_lu_we) begin
                r_lu_valid <= 1'b1;
                r_lu_way   <= i_lu_way;
            end
            if (i_rr_we)
                r_rr_ptr <= i_rr_nxt;
        end
    end

    assign o_lu_valid = r_lu_valid;
    assign o_lu_way   = r_lu_way;
    assign o_rr_ptr   = r_rr_ptr;
endmodule

module victim_select_param #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mode,
    input  logic             i_access_valid,
    input  logic [SET_W-1:0] i_access_set,
    input  logic [WAY_W-1:0] i_access_way,
    input  logic             i_req_valid,
    input  logic [SET_W-1:0] i_req_set,
    input  logic [WAYS-1:0]  i_way_valid,
    input  logic [WAYS-1:0]  i_way_locked,
    output logic             o_victim_valid,
    output logic [WAY_W-1:0] o_victim_way,
    output logic             o_victim_none
);
    function automatic logic [WAY_W-1:0] lowest_idx(input logic [WAYS-1:0] m);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (m[i]) idx = WAY_W'(i);
        return idx;
    endfunction

    logic [SETS-1:0]            w_lu_valid_a;
    logic [SETS-1:0][WAY_W-1:0] w_lu_way_a;
    logic [SETS-1:0][WAY_W-1:0] w_rr_ptr_a;

    logic [WAYS-1:0]  w_inv, w_elig, w_excl;
    logic             w_lu_valid;
    logic [WAY_W-1:0] w_lu_way, w_rr_ptr, w_rr_pick, w_pick, w_rr_nxt;
    logic             w_none, w_rr_upd;

    logic             r_vld, r_none;
    logic [WAY_W-1:0] r_way;

    assign w_inv      = ~i_way_valid & ~i_way_locked;
    assign w_elig     =  i_way_valid & ~i_way_locked;
    assign w_lu_valid = w_lu_valid_a[i_req_set];
    assign w_lu_way   = w_lu_way_a[i_req_set];
    assign w_rr_ptr   = w_rr_ptr_a[i_req_set];

    always_comb begin
        w_excl = w_elig;
        if (w_lu_valid)
            w_excl[w_lu_way] = 1'b0;
        // Scan downward so the smallest offset from the pointer wins; WAY_W-bit add wraps.
        w_rr_pick = '0;
        for (int k = WAYS - 1; k >= 0; k--)
            if (w_elig[w_rr_ptr + WAY_W'(k)]) w_rr_pick = w_rr_ptr + WAY_W'(k);
    end

    always_comb begin
        w_pick = '0;
        w_none = 1'b0;
        if (|w_inv)
            w_pick = lowest_idx(w_inv);
        else if (i_mode) begin
            if (|w_elig) w_pick = w_rr_pick;
            else         w_none = 1'b1;
        end else begin
            if (|w_excl)      w_pick = lowest_idx(w_excl);
            else if (|w_elig) w_pick = w_lu_way;
            else              w_none = 1'b1;
        end
    end

    assign w_rr_upd = i_req_valid & i_mode & ~w_none;
    assign w_rr_nxt = w_pick + WAY_W'(1);

    genvar g;
    generate
        for (g = 0; g < SETS; g++) begin : g_set
            victim_select_set #(.WAY_W(WAY_W)) u_set (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_lu_we    (i_access_valid && (i_access_set == SET_W'(g))),
                .i_lu_way   (i_access_way),
                .i_rr_we    (w_rr_upd && (i_req_set == SET_W'(g))),
                .i_rr_nxt   (w_rr_nxt),
                .o_lu_valid (w_lu_valid_a[g]),
                .o_lu_way   (w_lu_way_a[g]),
                .o_rr_ptr   (w_rr_ptr_a[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_none <= 1'b0;
            r_way  <= '0;
        end else if (i_req_valid) begin
            r_vld  <= 1'b1;
            r_none <= w_none;
            r_way  <= w_pick;
        end else begin
            r_vld  <= 1'b0;
            r_none <= 1'b0;
        end
    end

    assign o_victim_valid = r_vld;
    assign o_victim_way   = r_way;
    assign o_victim_none  = r_none;
endmodule
